execute_muldiv_ctrl: RTL

EXECUTE_MULDIV_CTRL -- requirements
Module: execute_muldiv_ctrl

---
 rtl/execute_muldiv_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/execute_muldiv_ctrl.sv
// execute_muldiv_ctrl
//   Iterative multiply/divide unit for the execute stage, with the HI/LO
//   register pair. Multiply uses one shift-add step per cycle. Divide uses
//   one restoring shift-subtract step per cycle. A FIX cycle applies the
//   sign corrections and writes HI/LO, then a one-cycle DONE state follows.
//
// Configuration macro:
//   EXEC_MULDIV_DIV_EN - when defined, the divide datapath is built.
//                        When undefined, DIVU/DIV (i_Op = 1x) are ignored.
//
// Ports:
//   i_CLK, i_RST_n     clock (rising edge), asynchronous active-low reset
//   i_Start, i_Op      request strobe; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   i_OperA, i_OperB   operands (dividend / divisor for divide)
//   i_Abort            pipeline flush; cancels any operation in flight
//   i_HiWrite/LoWrite  MTHI / MTLO strobes, with data on i_WriteData
//   o_Busy             stall request to the pipeline
//   o_Done             one-cycle completion pulse
//   o_DivByZero        pulses together with o_Done on divide by zero
//   o_Hi, o_Lo         architectural HI/LO registers
module execute_muldiv_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_n,
  input  logic                  i_Start,
  input  logic [1:0]            i_Op,
  input  logic [DATA_WIDTH-1:0] i_OperA,
  input  logic [DATA_WIDTH-1:0] i_OperB,
  input  logic                  i_Abort,
  input  logic                  i_HiWrite,
  input  logic                  i_LoWrite,
  input  logic [DATA_WIDTH-1:0] i_WriteData,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_DivByZero,
  output logic [DATA_WIDTH-1:0] o_Hi,
  output logic [DATA_WIDTH-1:0] o_Lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  // hi_acc/lo_acc hold the product (multiply) or the remainder/quotient
  // (divide). opb holds the multiplicand or divisor magnitude.
  logic [W-1:0]    hi_acc_reg;
  logic [W-1:0]    lo_acc_reg;
  logic [W-1:0]    opb_reg;
  logic            neg_lo_reg;   // sign(A) ^ sign(B): negate product / quotient
  logic            busy_reg;
  logic            done_reg;
  logic            dbz_reg;
  logic [W-1:0]    hi_reg;
  logic [W-1:0]    lo_reg;
`ifdef EXEC_MULDIV_DIV_EN
  logic            is_div_reg;
  logic            neg_hi_reg;   // sign(A): negate remainder
`endif

  // Start acceptance and operand preparation
  logic         op_ok;
  logic         idle_like;
  logic         accept;
  logic         sign_a;
  logic         sign_b;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;

  always_comb begin
`ifdef EXEC_MULDIV_DIV_EN
    op_ok = 1'b1;
`else
    op_ok = ~i_Op[1];
`endif
    idle_like = (state_reg == S_IDLE) || (state_reg == S_DONE);
    accept    = idle_like & i_Start & ~i_Abort & op_ok;
    sign_a    = i_Op[0] & i_OperA[W-1];
    sign_b    = i_Op[0] & i_OperB[W-1];
    mag_a     = sign_a ? (-i_OperA) : i_OperA;
    mag_b     = sign_b ? (-i_OperB) : i_OperB;
  end

  // The stall is raised in the same cycle as the request so the pipeline
  // holds the mul/div instruction. Reset must still force it low.
  assign o_Busy = i_RST_n & (busy_reg | accept);

  // One iteration step
  logic [W:0]   mul_sum;
  logic [W-1:0] iter_hi;
  logic [W-1:0] iter_lo;
`ifdef EXEC_MULDIV_DIV_EN
  logic [W:0]   div_shift;
  logic         div_ge;
  logic [W-1:0] div_diff;
`endif

  always_comb begin
    // Shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift the whole {carry, hi, lo} right by one.
    mul_sum = {1'b0, hi_acc_reg} + (lo_acc_reg[0] ? {1'b0, opb_reg} : {(W+1){1'b0}});
    iter_hi = mul_sum[W:1];
    iter_lo = {mul_sum[0], lo_acc_reg[W-1:1]};
`ifdef EXEC_MULDIV_DIV_EN
    // Restoring divide: shift the next dividend bit into the remainder, and
    // subtract the divisor if that fits. The compare uses the full W+1 bits.
    // On a pass the difference always fits in W bits.
    div_shift = {hi_acc_reg, lo_acc_reg[W-1]};
    div_ge    = div_shift >= {1'b0, opb_reg};
    div_diff  = div_shift[W-1:0] - opb_reg;
    if (is_div_reg) begin
      iter_hi = div_ge ? div_diff : div_shift[W-1:0];
      iter_lo = {lo_acc_reg[W-2:0], div_ge};
    end
`endif
  end

  // FIX-stage result
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   res_hi;
  logic [W-1:0]   res_lo;
  logic           res_dbz;

  always_comb begin
    prod     = {hi_acc_reg, lo_acc_reg};
    prod_fix = neg_lo_reg ? (-prod) : prod;
    res_hi   = prod_fix[2*W-1:W];
    res_lo   = prod_fix[W-1:0];
    res_dbz  = 1'b0;
`ifdef EXEC_MULDIV_DIV_EN
    if (is_div_reg) begin
      // With a zero divisor every step "subtracts", so the remainder ends
      // up equal to |A|. Restoring the sign of A therefore gives back the
      // original dividend for HI.
      res_hi = neg_hi_reg ? (-hi_acc_reg) : hi_acc_reg;
      if (opb_reg == '0) begin
        res_dbz = 1'b1;
        res_lo  = '1;
      end else begin
        res_lo = neg_lo_reg ? (-lo_acc_reg) : lo_acc_reg;
      end
    end
`endif
  end

  // Control FSM and registers
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      hi_acc_reg <= '0;
      lo_acc_reg <= '0;
      opb_reg    <= '0;
      neg_lo_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
`ifdef EXEC_MULDIV_DIV_EN
      is_div_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: begin
          // An MTHI/MTLO here lands even alongside a start. The result
          // written in FIX overwrites it later.
          if (i_HiWrite) hi_reg <= i_WriteData;
          if (i_LoWrite) lo_reg <= i_WriteData;
          if (accept) begin
            state_reg  <= S_CALC;
            busy_reg   <= 1'b1;
            cnt_reg    <= CW'(W - 1);
            hi_acc_reg <= '0;
            lo_acc_reg <= mag_a;
            opb_reg    <= mag_b;
            neg_lo_reg <= sign_a ^ sign_b;
`ifdef EXEC_MULDIV_DIV_EN
            is_div_reg <= i_Op[1];
            neg_hi_reg <= sign_a;
`endif
          end else begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        S_CALC: begin
          if (i_Abort) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            hi_acc_reg <= iter_hi;
            lo_acc_reg <= iter_lo;
            if (cnt_reg == '0) state_reg <= S_FIX;
            else               cnt_reg   <= cnt_reg - CW'(1);
          end
        end
        S_FIX: begin
          busy_reg <= 1'b0;
          if (i_Abort) begin
            state_reg <= S_IDLE;
          end else begin
            hi_reg    <= res_hi;
            lo_reg    <= res_lo;
            done_reg  <= 1'b1;
            dbz_reg   <= res_dbz;
            state_reg <= S_DONE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Done      = done_reg;
  assign o_DivByZero = dbz_reg;
  assign o_Hi        = hi_reg;
  assign o_Lo        = lo_reg;

endmodule
